// File: rtl/adc_scan_averager.sv
// Scans LTC2308 channels, re-attributes each pipelined result to its channel and box-car averages 2^AVG_LOG2 samples.
// Latency: avg_valid one cycle after the frame end of the last sample; rd_data is a same-cycle register-file read.
module adc_scan_averager #(
  parameter int NUM_CHAN     = 8,
  parameter int FRAME_CYCLES = 20,
  parameter int AVG_LOG2     = 2,
  parameter int CHAN_LAG     = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic [2:0]  chan,
  input  logic [11:0] adc_result,
  output logic        avg_valid,
  output logic [2:0]  avg_chan,
  output logic [11:0] avg_data,
  input  logic [2:0]  rd_chan,
  output logic [11:0] rd_data
);

  localparam int FCW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int PCW = (CHAN_LAG > 1) ? $clog2(CHAN_LAG) : 1;
  localparam int AW  = 12 + AVG_LOG2;
  localparam int CW  = AVG_LOG2 + 1;
  localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAME_CYCLES - 1);
  localparam logic [PCW-1:0] PRIME_LAST = PCW'(CHAN_LAG - 1);
  localparam logic [CW-1:0]  CNT_LAST   = CW'((1 << AVG_LOG2) - 1);
  localparam logic [2:0]     CHAN_LAST  = 3'(NUM_CHAN - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_SCAN} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [FCW-1:0]   r_frame_cnt;
  logic [PCW-1:0]   r_prime_cnt;
  logic [2:0]       r_chan;
  logic [2:0]       r_hist [CHAN_LAG];
  logic [AW-1:0]    r_acc [8];
  logic [CW-1:0]    r_cnt [8];
  logic [11:0]      r_regfile [8];
  logic             r_avg_valid;
  logic [2:0]       r_avg_chan;
  logic [11:0]      r_avg_data;

  logic             w_frame_end;
  logic [2:0]       w_owner;
  logic [AW-1:0]    w_sum;
  logic [11:0]      w_avg;
  logic             w_last;

  assign w_frame_end = (r_state != ST_IDLE) && (r_frame_cnt == FRAME_LAST);
  // Oldest history entry is the channel whose conversion is being read out now.
  assign w_owner     = r_hist[CHAN_LAG-1];
  assign w_sum       = r_acc[w_owner] + AW'(adc_result);
  assign w_avg       = 12'(w_sum >> AVG_LOG2);
  assign w_last      = (r_cnt[w_owner] == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (!enable) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  w_next_state = ST_PRIME;
        ST_PRIME: if (w_frame_end && (r_prime_cnt == PRIME_LAST)) w_next_state = ST_SCAN;
        default:  w_next_state = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_chan      <= '0;
      r_frame_cnt <= '0;
      r_prime_cnt <= '0;
      r_avg_valid <= 1'b0;
      r_avg_chan  <= '0;
      r_avg_data  <= '0;
      for (int i = 0; i < CHAN_LAG; i++) r_hist[i] <= '0;
      for (int i = 0; i < 8; i++) begin
        r_acc[i]     <= '0;
        r_cnt[i]     <= '0;
        r_regfile[i] <= '0;
      end
    end else begin
      r_avg_valid <= 1'b0;
      if (!enable) begin
        // Partial averages are dropped; channel pointer and published results survive.
        r_frame_cnt <= '0;
        r_prime_cnt <= '0;
        for (int i = 0; i < CHAN_LAG; i++) r_hist[i] <= '0;
        for (int i = 0; i < 8; i++) begin
          r_acc[i] <= '0;
          r_cnt[i] <= '0;
        end
      end else begin
        if (r_state == ST_IDLE || w_frame_end) r_frame_cnt <= '0;
        else                                   r_frame_cnt <= r_frame_cnt + 1'b1;

        if (w_frame_end) begin
          r_chan <= (r_chan == CHAN_LAST) ? 3'd0 : r_chan + 3'd1;
          for (int i = CHAN_LAG - 1; i > 0; i--) r_hist[i] <= r_hist[i-1];
          r_hist[0] <= r_chan;
          if (r_state == ST_PRIME) r_prime_cnt <= r_prime_cnt + 1'b1;
          if (r_state == ST_SCAN) begin
            if (w_last) begin
              r_avg_valid        <= 1'b1;
              r_avg_chan         <= w_owner;
              r_avg_data         <= w_avg;
              r_regfile[w_owner] <= w_avg;
              r_acc[w_owner]     <= '0;
              r_cnt[w_owner]     <= '0;
            end else begin
              r_acc[w_owner] <= w_sum;
              r_cnt[w_owner] <= r_cnt[w_owner] + 1'b1;
            end
          end
        end
      end
    end
  end

  assign chan      = r_chan;
  assign avg_valid = r_avg_valid;
  assign avg_chan  = r_avg_chan;
  assign avg_data  = r_avg_data;
  assign rd_data   = (int'(rd_chan) < NUM_CHAN) ? r_regfile[rd_chan] : 12'd0;

endmodule
